// File: rtl/sdram_bridge_pkg.sv
// Shared types and constants for the 32-bit CPU bus to 16-bit SDRAM command bridge.
package sdram_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LO_CMD,
        LO_WAIT,
        HI_CMD,
        HI_WAIT,
        DONE
    } state_t;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam int DEFAULT_RD_TIMEOUT = 64;

    // A halfword is touched when any of its two byte lanes is enabled.
    function automatic logic half_enabled(input logic [1:0] be_half);
        return |be_half;
    endfunction

endpackage

// File: rtl/sdram_rd_timer.sv
// Loadable down-counter bounding how long the bridge waits for read data.
module sdram_rd_timer #(
    parameter int LOAD_VALUE = 63
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int CW = (LOAD_VALUE > 0) ? $clog2(LOAD_VALUE + 1) : 1;

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= CW'(LOAD_VALUE);
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/sdram_bus_bridge.sv
// Splits single 32-bit CPU word accesses into one or two 16-bit SDRAM controller
// commands and reassembles read data; one CPU transaction in flight at a time.
module sdram_bus_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int CPU_AW     = 23,
    parameter int RD_TIMEOUT = DEFAULT_RD_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [CPU_AW-1:0] cpu_addr,
    input  logic [3:0]        cpu_be,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              cpu_busy,
    output logic              sd_valid,
    input  logic              sd_ready,
    output logic              sd_we,
    output logic [CPU_AW:0]   sd_addr,
    output logic [15:0]       sd_wdata,
    input  logic              sd_rvalid,
    input  logic [15:0]       sd_rdata
);

    state_t state_reg, state_next;

    logic              txn_we_reg,    txn_we_next;
    logic [CPU_AW-1:0] txn_addr_reg,  txn_addr_next;
    logic [3:0]        txn_be_reg,    txn_be_next;
    logic [31:0]       txn_wdata_reg, txn_wdata_next;

    logic [31:0]       cpu_rdata_reg;
    logic              cpu_ack_reg;
    logic              cpu_err_reg;
    logic              cpu_busy_reg;
    logic              sd_valid_reg;
    logic              sd_we_reg;
    logic [CPU_AW:0]   sd_addr_reg;
    logic [15:0]       sd_wdata_reg;

    logic accept;
    logic timeout_hit;
    logic timer_load;
    logic timer_dec;
    logic timer_expired;

    sdram_rd_timer #(
        .LOAD_VALUE(RD_TIMEOUT - 1)
    ) u_rd_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .dec     (timer_dec),
        .expired (timer_expired)
    );

    always_comb begin
        state_next     = state_reg;
        accept         = 1'b0;
        timeout_hit    = 1'b0;
        timer_load     = 1'b0;
        timer_dec      = 1'b0;
        txn_we_next    = txn_we_reg;
        txn_addr_next  = txn_addr_reg;
        txn_be_next    = txn_be_reg;
        txn_wdata_next = txn_wdata_reg;

        case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    accept         = 1'b1;
                    txn_we_next    = cpu_we;
                    txn_addr_next  = cpu_addr;
                    txn_be_next    = cpu_be;
                    txn_wdata_next = cpu_wdata;
                    // Writes skip straight to the first enabled half.
                    if (!cpu_we || half_enabled(cpu_be[1:0])) begin
                        state_next = LO_CMD;
                    end else if (half_enabled(cpu_be[3:2])) begin
                        state_next = HI_CMD;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            LO_CMD: begin
                if (sd_ready) begin
                    if (!txn_we_reg) begin
                        state_next = LO_WAIT;
                        timer_load = 1'b1;
                    end else if (half_enabled(txn_be_reg[3:2])) begin
                        state_next = HI_CMD;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            LO_WAIT: begin
                if (sd_rvalid) begin
                    state_next = HI_CMD;
                end else if (timer_expired) begin
                    state_next  = DONE;
                    timeout_hit = 1'b1;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            HI_CMD: begin
                if (sd_ready) begin
                    if (txn_we_reg) begin
                        state_next = DONE;
                    end else begin
                        state_next = HI_WAIT;
                        timer_load = 1'b1;
                    end
                end
            end
            HI_WAIT: begin
                if (sd_rvalid) begin
                    state_next = DONE;
                end else if (timer_expired) begin
                    state_next  = DONE;
                    timeout_hit = 1'b1;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            txn_we_reg    <= 1'b0;
            txn_addr_reg  <= '0;
            txn_be_reg    <= '0;
            txn_wdata_reg <= '0;
            cpu_rdata_reg <= '0;
            cpu_ack_reg   <= 1'b0;
            cpu_err_reg   <= 1'b0;
            cpu_busy_reg  <= 1'b0;
            sd_valid_reg  <= 1'b0;
            sd_we_reg     <= 1'b0;
            sd_addr_reg   <= '0;
            sd_wdata_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            txn_we_reg    <= txn_we_next;
            txn_addr_reg  <= txn_addr_next;
            txn_be_reg    <= txn_be_next;
            txn_wdata_reg <= txn_wdata_next;

            cpu_ack_reg  <= (state_next == DONE);
            cpu_busy_reg <= (state_next != IDLE);
            sd_valid_reg <= (state_next == LO_CMD) || (state_next == HI_CMD);

            if (state_next == LO_CMD) begin
                sd_addr_reg  <= {txn_addr_next, HALF_LO};
                sd_wdata_reg <= txn_wdata_next[15:0];
                sd_we_reg    <= txn_we_next;
            end else if (state_next == HI_CMD) begin
                sd_addr_reg  <= {txn_addr_next, HALF_HI};
                sd_wdata_reg <= txn_wdata_next[31:16];
                sd_we_reg    <= txn_we_next;
            end

            if (accept) begin
                cpu_err_reg <= 1'b0;
                if (!cpu_we) begin
                    cpu_rdata_reg <= '0;
                end
            end else if (timeout_hit) begin
                cpu_err_reg <= 1'b1;
            end

            if ((state_reg == LO_WAIT) && sd_rvalid) begin
                cpu_rdata_reg[15:0] <= sd_rdata;
            end
            if ((state_reg == HI_WAIT) && sd_rvalid) begin
                cpu_rdata_reg[31:16] <= sd_rdata;
            end
        end
    end

    assign cpu_rdata = cpu_rdata_reg;
    assign cpu_ack   = cpu_ack_reg;
    assign cpu_err   = cpu_err_reg;
    assign cpu_busy  = cpu_busy_reg;
    assign sd_valid  = sd_valid_reg;
    assign sd_we     = sd_we_reg;
    assign sd_addr   = sd_addr_reg;
    assign sd_wdata  = sd_wdata_reg;

endmodule

// File: tb/tb_sdram_bus_bridge.sv
// Scoreboard bench: stimulus pushes expected SDRAM commands and CPU responses,
// a negedge monitor pops and compares them; a behavioural SDRAM answers reads.
module tb_sdram_bus_bridge;

    localparam int CPU_AW     = 23;
    localparam int RD_TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [CPU_AW-1:0] cpu_addr;
    logic [3:0]        cpu_be;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;
    logic              cpu_busy;
    logic              sd_valid;
    logic              sd_ready  = 1'b0;
    logic              sd_we;
    logic [CPU_AW:0]   sd_addr;
    logic [15:0]       sd_wdata;
    logic              sd_rvalid = 1'b0;
    logic [15:0]       sd_rdata  = 16'h0;

    always #5 clk = ~clk;

    sdram_bus_bridge #(
        .CPU_AW     (CPU_AW),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_be    (cpu_be),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .cpu_busy  (cpu_busy),
        .sd_valid  (sd_valid),
        .sd_ready  (sd_ready),
        .sd_we     (sd_we),
        .sd_addr   (sd_addr),
        .sd_wdata  (sd_wdata),
        .sd_rvalid (sd_rvalid),
        .sd_rdata  (sd_rdata)
    );

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [15:0] wdata;
    } cmd_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          ack_cyc;
    } rsp_t;

    cmd_t exp_cmd_q[$];
    rsp_t exp_rsp_q[$];

    logic [15:0] model_mem [logic [23:0]];
    logic [15:0] sdram_mem [logic [23:0]];
    logic [31:0] last_rdata = 32'h0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int ready_pct      = 100;
    bit ready_hold_low = 1'b0;
    bit no_rvalid      = 1'b0;
    bit spur_en        = 1'b0;
    int rd_lat_fixed   = 2;
    int hi_rd_count    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] fill_hw(input logic [23:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] model_rd(input logic [23:0] a);
        return model_mem.exists(a) ? model_mem[a] : fill_hw(a);
    endfunction

    function automatic logic [15:0] sdram_rd(input logic [23:0] a);
        return sdram_mem.exists(a) ? sdram_mem[a] : fill_hw(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Behavioural SDRAM: stores writes, returns read halfwords after a latency.
    initial begin
        int          rd_cd;
        logic [23:0] rd_addr;
        rd_cd   = -1;
        rd_addr = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                rd_cd = -1;
            end else if (sd_valid && sd_ready) begin
                if (sd_we) begin
                    sdram_mem[sd_addr] = sd_wdata;
                end else begin
                    rd_addr = sd_addr;
                    if (sd_addr[0]) hi_rd_count++;
                    if (no_rvalid) rd_cd = -1;
                    else if (rd_lat_fixed > 0) rd_cd = rd_lat_fixed;
                    else rd_cd = int'($urandom_range(1, 4));
                end
            end
            @(posedge clk);
            #1;
            sd_ready  = ready_hold_low ? 1'b0 : ($urandom_range(1, 100) <= ready_pct);
            sd_rvalid = 1'b0;
            sd_rdata  = 16'($urandom);
            if (rd_cd > 0) begin
                rd_cd--;
                if (rd_cd == 0) begin
                    sd_rvalid = 1'b1;
                    sd_rdata  = sdram_rd(rd_addr);
                    rd_cd     = -1;
                end
            end else if (spur_en && ($urandom_range(0, 3) == 0)) begin
                sd_rvalid = 1'b1;
            end
        end
    end

    // Monitor: SDRAM transfers, CPU acks, handshake stability and ack pulse width.
    always @(negedge clk) begin
        static bit          prev_stall = 1'b0;
        static bit          prev_ack   = 1'b0;
        static logic [23:0] prev_addr  = '0;
        static logic [15:0] prev_wdata = '0;
        static logic        prev_we    = 1'b0;
        cmd_t c;
        rsp_t r;
        if (reset === 1'b1) begin
            if (prev_stall) begin
                chk("stall_hold_valid", 32'(sd_valid), 32'd1);
                chk("stall_hold_addr", 32'(sd_addr), 32'(prev_addr));
                chk("stall_hold_wdata", 32'(sd_wdata), 32'(prev_wdata));
                chk("stall_hold_we", 32'(sd_we), 32'(prev_we));
            end
            prev_stall = sd_valid && !sd_ready;
            prev_addr  = sd_addr;
            prev_wdata = sd_wdata;
            prev_we    = sd_we;

            if (sd_valid && sd_ready) begin
                if (exp_cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd actual we=%0d addr=0x%0h required none (cycle %0d)",
                             sd_we, sd_addr, cyc);
                end else begin
                    c = exp_cmd_q.pop_front();
                    chk("cmd_we", 32'(sd_we), 32'(c.we));
                    chk("cmd_addr", 32'(sd_addr), 32'(c.addr));
                    if (c.we) chk("cmd_wdata", 32'(sd_wdata), 32'(c.wdata));
                end
            end

            if (prev_ack) begin
                chk("ack_single_cycle", 32'(cpu_ack), 32'd0);
                chk("busy_after_ack", 32'(cpu_busy), 32'd0);
            end
            prev_ack = cpu_ack;

            if (cpu_ack) begin
                if (exp_rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack actual ack=1 required none (cycle %0d)", cyc);
                end else begin
                    r = exp_rsp_q.pop_front();
                    chk("ack_err", 32'(cpu_err), 32'(r.err));
                    chk("ack_rdata", cpu_rdata, r.rdata);
                    chk("ack_busy", 32'(cpu_busy), 32'd1);
                    if (r.ack_cyc >= 0) chk("ack_cycle", 32'(cyc), 32'(r.ack_cyc));
                end
            end
        end else begin
            prev_stall = 1'b0;
            prev_ack   = 1'b0;
        end
    end

    // Reference model: decides which halves go out and what the CPU should see.
    task automatic issue(input logic we, input logic [22:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input int exp_lat, input bit timeout);
        int   n;
        cmd_t c;
        rsp_t r;
        n = 0;
        while (cpu_busy !== 1'b0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL busy_stuck actual busy=%0b required 0", cpu_busy);
        end
        if (we) begin
            if (be[1:0] != 2'b00) begin
                c = '{1'b1, {addr, 1'b0}, wdata[15:0]};
                exp_cmd_q.push_back(c);
                model_mem[{addr, 1'b0}] = wdata[15:0];
            end
            if (be[3:2] != 2'b00) begin
                c = '{1'b1, {addr, 1'b1}, wdata[31:16]};
                exp_cmd_q.push_back(c);
                model_mem[{addr, 1'b1}] = wdata[31:16];
            end
            r.err   = 1'b0;
            r.rdata = last_rdata;
        end else begin
            c = '{1'b0, {addr, 1'b0}, 16'h0};
            exp_cmd_q.push_back(c);
            if (timeout) begin
                r.err   = 1'b1;
                r.rdata = 32'h0;
            end else begin
                c = '{1'b0, {addr, 1'b1}, 16'h0};
                exp_cmd_q.push_back(c);
                r.err   = 1'b0;
                r.rdata = {model_rd({addr, 1'b1}), model_rd({addr, 1'b0})};
            end
            last_rdata = r.rdata;
        end
        r.ack_cyc = (exp_lat >= 0) ? cyc + exp_lat : -1;
        exp_rsp_q.push_back(r);
        $display("txn cycle=%0d we=%0b addr=0x%0h be=%b wdata=0x%08h exp_rdata=0x%08h exp_err=%0b",
                 cyc, we, addr, be, wdata, r.rdata, r.err);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_be    = be;
        cpu_wdata = wdata;
        @(posedge clk);
        #1;
        cpu_req   = 1'b0;
        cpu_we    = 1'($urandom);
        cpu_addr  = 23'($urandom);
        cpu_be    = 4'($urandom);
        cpu_wdata = $urandom;
    endtask

    task automatic poke_busy();
        chk("poke_while_busy", 32'(cpu_busy), 32'd1);
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom);
        cpu_addr  = 23'($urandom);
        cpu_be    = 4'($urandom);
        cpu_wdata = $urandom;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_rsp_q.size() != 0 || cpu_busy !== 1'b0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL wait_done actual pending=%0d busy=%0b required 0/0", exp_rsp_q.size(), cpu_busy);
            exp_cmd_q.delete();
            exp_rsp_q.delete();
        end
    endtask

    initial begin
        int snap;
        int n;
        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_be    = '0;
        cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sd_valid", 32'(sd_valid), 32'd0);
        chk("rst_sd_we", 32'(sd_we), 32'd0);
        chk("rst_sd_addr", 32'(sd_addr), 32'd0);
        chk("rst_sd_wdata", 32'(sd_wdata), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_cpu_busy", 32'(cpu_busy), 32'd0);
        chk("rst_cpu_err", 32'(cpu_err), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed: full write, seeded read, partial writes and read-back.
        issue(1'b1, 23'h000010, 4'b1111, 32'hDEADBEEF, 3, 1'b0);
        wait_done();
        model_mem[24'h000040] = 16'h5678;
        model_mem[24'h000041] = 16'h1234;
        sdram_mem[24'h000040] = 16'h5678;
        sdram_mem[24'h000041] = 16'h1234;
        issue(1'b0, 23'h000020, 4'b0000, 32'h0, 7, 1'b0);
        wait_done();
        chk("read_word", cpu_rdata, 32'h12345678);
        chk("read_err", 32'(cpu_err), 32'd0);
        issue(1'b1, 23'h000011, 4'b0011, 32'hCAFEF00D, 2, 1'b0);
        wait_done();
        issue(1'b1, 23'h000012, 4'b0100, 32'h0BADC0DE, 2, 1'b0);
        wait_done();
        issue(1'b1, 23'h000013, 4'b0000, 32'h11111111, 1, 1'b0);
        wait_done();
        issue(1'b0, 23'h000011, 4'b0000, 32'h0, 7, 1'b0);
        issue(1'b0, 23'h000012, 4'b0000, 32'h0, -1, 1'b0);
        issue(1'b0, 23'h000010, 4'b0000, 32'h0, -1, 1'b0);
        wait_done();

        // Backpressure on the low command with ignored requests while busy.
        ready_hold_low = 1'b1;
        issue(1'b1, 23'h000014, 4'b1111, 32'h89ABCDEF, -1, 1'b0);
        for (int i = 0; i < 5; i++) poke_busy();
        ready_hold_low = 1'b0;
        wait_done();

        // Read timeout: controller never returns data.
        no_rvalid = 1'b1;
        issue(1'b0, 23'h000015, 4'b0000, 32'h0, 2 + RD_TIMEOUT, 1'b1);
        wait_done();
        no_rvalid = 1'b0;
        chk("timeout_err_hold", 32'(cpu_err), 32'd1);
        chk("timeout_rdata", cpu_rdata, 32'd0);

        // Reset while waiting for the high read half.
        rd_lat_fixed = 6;
        snap = hi_rd_count;
        issue(1'b0, 23'h000016, 4'b0000, 32'h0, -1, 1'b0);
        n = 0;
        while (hi_rd_count == snap && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hi_read_reached", 32'(hi_rd_count - snap), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_sd_valid", 32'(sd_valid), 32'd0);
        chk("midrst_cpu_busy", 32'(cpu_busy), 32'd0);
        chk("midrst_cpu_ack", 32'(cpu_ack), 32'd0);
        reset = 1'b1;
        exp_cmd_q.delete();
        exp_rsp_q.delete();
        last_rdata   = 32'h0;
        rd_lat_fixed = 2;
        @(posedge clk);
        #1;
        issue(1'b0, 23'h000010, 4'b0000, 32'h0, 7, 1'b0);
        wait_done();

        // Randomized traffic with random backpressure, latency and stray rvalid.
        ready_pct    = 70;
        rd_lat_fixed = 0;
        spur_en      = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)), 23'($urandom_range(16, 23)), 4'($urandom),
                  $urandom, -1, 1'b0);
        end
        for (int a = 16; a < 24; a++) begin
            issue(1'b0, 23'(a), 4'b0000, 32'h0, -1, 1'b0);
        end
        wait_done();

        chk("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
        chk("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sdram_bus_bridge.md
Name: sdram_bus_bridge

Overview:
- Upstream neighbour of the SDRAM controller.
- Accepts single 32-bit word reads and writes from the CPU-side memory bus and splits each into one or two 16-bit halfword accesses on the controller's command interface.
- Returns reassembled 32-bit read data with an ack pulse and an error flag on read timeout.
- Only one CPU transaction is in flight at a time.

Parameters:
- CPU_AW, 23, CPU word-address width; the SDRAM halfword address is CPU_AW+1 = 24 bits.
- RD_TIMEOUT, 64, maximum cycles to wait for sd_rvalid after a read command is accepted.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-low reset.
- cpu_req  in  1  one-cycle request pulse; accepted only when cpu_busy=0.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  CPU_AW  word address.
- cpu_be  in  4  byte enables, write only.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data, valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_ack; 1 = read timeout.
- cpu_busy  out  1  transaction in progress.
- sd_valid  out  1  command valid to the controller.
- sd_ready  in  1  controller accepts the command.
- sd_we  out  1  command is a write.
- sd_addr  out  24  halfword address.
- sd_wdata  out  16  write halfword.
- sd_rvalid  in  1  read halfword returned.
- sd_rdata  in  16  read halfword.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0: cpu_rdata, cpu_ack, cpu_err, cpu_busy, sd_valid, sd_we, sd_addr, sd_wdata.
  - Timeout counter is cleared.
  - A transaction in progress is abandoned with no ack; sd_valid drops at that edge.
- States and transitions:
  - IDLE: on cpu_req, latch we/addr/be/wdata, set cpu_busy=1, and go to LO_CMD. Reads go to LO_CMD. Writes go to the first enabled half; be=0000 goes straight to DONE.
  - LO_CMD: sd_valid=1, sd_addr={addr,0}, sd_wdata=wdata[15:0].
    - On sd_ready, a write goes to HI_CMD if be[3:2]!=0, else DONE.
    - On sd_ready, a read goes to LO_WAIT.
  - LO_WAIT (read only): on sd_rvalid, capture rdata[15:0] and go to HI_CMD.
  - HI_CMD: sd_valid=1, sd_addr={addr,1}, sd_wdata=wdata[31:16].
    - On sd_ready, a write goes to DONE and a read goes to HI_WAIT.
  - HI_WAIT: on sd_rvalid, capture rdata[31:16] and go to DONE.
  - DONE: cpu_ack=1 for one cycle, cpu_busy=0 on the next cycle, return to IDLE.
- Half selection for writes:
  - The low half is written if be[1:0]!=00; the high half if be[3:2]!=00.
  - A partially enabled half (01 or 10) writes the whole halfword; the controller has no byte mask.
- Handshakes:
  - sd_valid, sd_addr, sd_we and sd_wdata stay stable while sd_valid=1 and sd_ready=0.
  - A transfer occurs on a cycle where sd_valid&&sd_ready.
  - sd_rvalid outside the WAIT states is ignored.
  - cpu_req while cpu_busy=1 is ignored, with no queueing.
  - cpu_req in the DONE cycle is ignored; cpu_busy is still 1 then.
- Latency:
  - Full write with sd_ready tied high: ack 3 cycles after the cpu_req cycle.
  - Read: ack 3 cycles plus both rvalid latencies after the cpu_req cycle.
- Timeout:
  - The counter clears on entry to a WAIT state and increments each cycle there.
  - When it reaches RD_TIMEOUT, go to DONE with cpu_err=1. Uncaptured halves read as 0.
  - Any remaining half is not issued.
- Outputs and registers:
  - cpu_rdata holds until the next accepted read and is cleared at read accept.
  - cpu_err holds until the next accept.
  - All outputs are registered.

Decomposition:
- Package sdram_bridge_pkg holds:
  - state encoding: IDLE, LO_CMD, LO_WAIT, HI_CMD, HI_WAIT, DONE;
  - half-select constants: HALF_LO=0, HALF_HI=1;
  - default RD_TIMEOUT.
- Sub-module sdram_rd_timer: loadable down-counter with a clear and an expired flag. It is optional; inlining is acceptable.

Test Plan:
- Write, sd_ready=1: addr=0x000010, be=1111, wdata=0xDEADBEEF.
  - Expect exactly two sd transfers: (0x000020, 0xBEEF, we=1) then (0x000021, 0xDEAD, we=1).
  - Expect ack 3 cycles after req, cpu_err=0.
- Read, rvalid returned 2 cycles after each accept with 0x5678 then 0x1234.
  - Expect cpu_rdata=0x12345678, cpu_err=0, ack a single cycle.
- Partial writes: be=0011 issues only the low command; be=0100 issues only the high command (full halfword); be=0000 gives ack with no sd_valid.
- Backpressure: sd_ready low for 5 cycles during LO_CMD.
  - sd_valid, sd_addr and sd_wdata stay stable.
  - cpu_req pulses while busy are ignored, with no extra transfers.
- Timeout: read where the controller never asserts rvalid.
  - Ack occurs RD_TIMEOUT cycles after LO_WAIT entry, with cpu_err=1 and cpu_rdata=0.
  - No HI command is issued.
- Reset=0 during HI_WAIT:
  - sd_valid, busy and ack are all 0 after the edge; state is IDLE.
  - A new read after reset completes normally.
